// File: rtl/alu_pkg.sv
// alu_pkg: types and helpers shared by the ALU decoder and the execute-stage ALU.
//   alu_ctrl_e   - 4-bit ALU control codes produced by the decoder
//   alu_state_e  - execute-unit sequencing states
//   XLEN_DEFAULT - default datapath width
//   SHAMT_W      - width of the shift-amount field taken from operand B
//   is_shift()   - true for SLL/SRL/SRA
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int SHAMT_W      = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_XOR  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_ctrl_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } alu_state_e;

  function automatic logic is_shift(input logic [3:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// alu_shift_iter: iterative 1-bit-per-step shifter.
// Ports:
//   clk, rst_n   - clock, async active-low reset
//   i_load       - capture i_a, i_shamt and i_ctrl into the work registers
//   i_step       - shift the work register one bit and decrement the counter
//   i_ctrl       - ALU code selecting SLL / SRL / SRA
//   i_a          - value to shift
//   i_shamt      - number of steps to perform
//   o_next       - work register after one more step (the final result when o_last)
//   o_last       - counter == 1: the next step is the final one
import alu_pkg::*;

module alu_shift_iter #(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [3:0]         i_ctrl,
  input  logic [XLEN-1:0]    i_a,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic [XLEN-1:0]    o_next,
  output logic               o_last
);

  logic [XLEN-1:0]    r_work;
  logic [SHAMT_W-1:0] r_cnt;
  logic [3:0]         r_ctrl;
  logic [XLEN-1:0]    w_next;

  always_comb begin
    w_next = r_work;
    case (r_ctrl)
      ALU_SLL: w_next = {r_work[XLEN-2:0], 1'b0};
      ALU_SRL: w_next = {1'b0, r_work[XLEN-1:1]};
      ALU_SRA: w_next = {r_work[XLEN-1], r_work[XLEN-1:1]};
      default: w_next = r_work;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work <= '0;
      r_cnt  <= '0;
      r_ctrl <= '0;
    end else if (i_load) begin
      r_work <= i_a;
      r_cnt  <= i_shamt;
      r_ctrl <= i_ctrl;
    end else if (i_step) begin
      r_work <= w_next;
      r_cnt  <= r_cnt - SHAMT_W'(1);
    end
  end

  assign o_next = w_next;
  assign o_last = (r_cnt == SHAMT_W'(1));

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with valid/ready on both sides and a
// single registered output slot. Logic/arithmetic/compare ops and zero-length
// shifts complete in one cycle; shifts of n > 0 bits run n cycles through an
// iterative shifter.
//
// Build option: ALU_EXEC_BARREL_SHIFT_EN - when defined, shifts use a
// combinational barrel shifter, every op takes one cycle and ST_SHIFT is
// never entered.
//
// Ports:
//   clk, rst_n              - clock, async active-low reset
//   flush                   - synchronous abort of the shift and the output slot
//   in_valid / in_ready     - request handshake
//   in_ctrl, in_a, in_b     - ALU code and operands (shift amount = in_b[4:0])
//   in_tag                  - destination tag, passed through
//   out_valid / out_ready   - result handshake; result held until taken
//   out_result, out_zero    - result and registered (result == 0)
//   out_illegal             - in_ctrl was not a defined code
//   out_tag                 - tag belonging to out_result
//   busy                    - FSM not in ST_IDLE
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | accepting requests whenever the output slot can take a result
// ST_SHIFT | iterative shift in progress, requests blocked
import alu_pkg::*;

module alu_exec_unit #(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_ctrl,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic             out_zero,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  alu_state_e r_state;
  alu_state_e w_state_nxt;

  logic               r_out_valid;
  logic [XLEN-1:0]    r_out_result;
  logic               r_out_zero;
  logic               r_out_illegal;
  logic [TAG_W-1:0]   r_out_tag;
  logic [TAG_W-1:0]   r_tag;

  logic               w_slot_free;
  logic               w_accept;
  logic               w_start_iter;
  logic               w_commit_shift;
  logic               w_step;
  logic [SHAMT_W-1:0] w_shamt;
  logic [XLEN-1:0]    w_alu_res;
  logic               w_alu_illegal;
  logic [XLEN-1:0]    w_shift_res;
  logic               w_shift_last;

  assign w_shamt     = in_b[SHAMT_W-1:0];
  assign w_slot_free = !r_out_valid || out_ready;
  assign w_accept    = in_valid && in_ready;

  // Single-cycle datapath. In the iterative build a shift only reaches this
  // path with a zero shift amount, where the result is operand A unchanged.
  always_comb begin
    w_alu_res     = '0;
    w_alu_illegal = 1'b0;
    case (in_ctrl)
      ALU_ADD:  w_alu_res = in_a + in_b;
      ALU_SUB:  w_alu_res = in_a - in_b;
      ALU_XOR:  w_alu_res = in_a ^ in_b;
      ALU_OR:   w_alu_res = in_a | in_b;
      ALU_AND:  w_alu_res = in_a & in_b;
`ifdef ALU_EXEC_BARREL_SHIFT_EN
      ALU_SLL:  w_alu_res = in_a << w_shamt;
      ALU_SRL:  w_alu_res = in_a >> w_shamt;
      ALU_SRA:  w_alu_res = $unsigned($signed(in_a) >>> w_shamt);
`else
      ALU_SLL:  w_alu_res = in_a;
      ALU_SRL:  w_alu_res = in_a;
      ALU_SRA:  w_alu_res = in_a;
`endif
      ALU_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      ALU_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, (in_a < in_b)};
      default:  w_alu_illegal = 1'b1;
    endcase
  end

`ifdef ALU_EXEC_BARREL_SHIFT_EN
  assign w_start_iter = 1'b0;
  assign w_shift_res  = '0;
  assign w_shift_last = 1'b0;
`else
  assign w_start_iter = is_shift(in_ctrl) && (w_shamt != '0);

  alu_shift_iter #(
    .XLEN (XLEN)
  ) u_shift_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_accept && w_start_iter),
    .i_step  (w_step),
    .i_ctrl  (in_ctrl),
    .i_a     (in_a),
    .i_shamt (w_shamt),
    .o_next  (w_shift_res),
    .o_last  (w_shift_last)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    in_ready       = 1'b0;
    w_step         = 1'b0;
    w_commit_shift = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = !flush && w_slot_free;
        if (in_valid && !flush && w_slot_free && w_start_iter) w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        // The last step is held back until the output slot can take it, so
        // the work register and counter freeze while the consumer stalls.
        if (!flush) begin
          if (!w_shift_last) begin
            w_step = 1'b1;
          end else if (w_slot_free) begin
            w_step         = 1'b1;
            w_commit_shift = 1'b1;
            w_state_nxt    = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (flush) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag <= '0;
    end else if (w_accept && w_start_iter) begin
      r_tag <= in_tag;
    end
  end

  // Flush only drops the valid bit; data registers keep their stale contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_out_result  <= '0;
      r_out_zero    <= 1'b0;
      r_out_illegal <= 1'b0;
      r_out_tag     <= '0;
    end else if (flush) begin
      r_out_valid   <= 1'b0;
    end else if (w_accept && !w_start_iter) begin
      r_out_valid   <= 1'b1;
      r_out_result  <= w_alu_res;
      r_out_zero    <= (w_alu_res == '0);
      r_out_illegal <= w_alu_illegal;
      r_out_tag     <= in_tag;
    end else if (w_commit_shift) begin
      r_out_valid   <= 1'b1;
      r_out_result  <= w_shift_res;
      r_out_zero    <= (w_shift_res == '0);
      r_out_illegal <= 1'b0;
      r_out_tag     <= r_tag;
    end else if (out_ready) begin
      r_out_valid   <= 1'b0;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_result  = r_out_result;
  assign out_zero    = r_out_zero;
  assign out_illegal = r_out_illegal;
  assign out_tag     = r_out_tag;
  assign busy        = (r_state == ST_SHIFT);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit: directed scenarios plus a randomized run
// checked against a plain-arithmetic reference model and an in-order queue.
module tb_alu_exec_unit;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_ctrl;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic             out_zero;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_illegal(out_illegal), .out_tag(out_tag),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Reference result: {illegal, result}
  function automatic logic [32:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b[4:0];
    case (c)
      4'd0: return {1'b0, a + b};
      4'd1: return {1'b0, a - b};
      4'd2: return {1'b0, a ^ b};
      4'd3: return {1'b0, a | b};
      4'd4: return {1'b0, a & b};
      4'd5: return {1'b0, a << sh};
      4'd6: return {1'b0, a >> sh};
      4'd7: return {1'b0, $unsigned($signed(a) >>> sh)};
      4'd8: return {1'b0, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0};
      4'd9: return {1'b0, (a < b) ? 32'd1 : 32'd0};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] c, input logic [31:0] b);
`ifdef ALU_EXEC_BARREL_SHIFT_EN
    return 1;
`else
    if ((c == 4'd5 || c == 4'd6 || c == 4'd7) && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
    return 1;
`endif
  endfunction

  task automatic set_in(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    in_valid = v; in_ctrl = c; in_a = a; in_b = b; in_tag = t;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    set_in(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    #22;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", out_result); end
    checks++; if ({out_zero, out_illegal, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {out_zero, out_illegal, busy}); end
    checks++; if (out_tag !== 5'd0) begin errors++; $display("FAIL reset_tag: got %0d want 0", out_tag); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add_sub();
    @(negedge clk); out_ready = 1'b1; set_in(1'b1, 4'd0, 32'h7FFF_FFFF, 32'd1, 5'd1);
    @(negedge clk); set_in(1'b1, 4'd1, 32'd5, 32'd5, 5'd2); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", out_valid); end
    checks++; if (out_result !== 32'h8000_0000) begin errors++; $display("FAIL add_result: got %h want 80000000", out_result); end
    checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL add_zero: got %b want 0", out_zero); end
    checks++; if (out_tag !== 5'd1) begin errors++; $display("FAIL add_tag: got %0d want 1", out_tag); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
    @(negedge clk); set_in(1'b0, 4'd0, 32'd0, 32'd0, 5'd0); #1;
    checks++; if (out_result !== 32'd0 || out_zero !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL sub_result: got %h zero %b valid %b want 0 1 1", out_result, out_zero, out_valid); end
    checks++; if (out_tag !== 5'd2) begin errors++; $display("FAIL sub_tag: got %0d want 2", out_tag); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sub_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_sra();
    int lat;
    @(negedge clk); out_ready = 1'b1; set_in(1'b1, 4'd7, 32'h8000_0000, 32'd4, 5'd3); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sra_accept: got %b want 1", in_ready); end
    @(negedge clk); set_in(1'b0, 4'd0, 32'd0, 32'd0, 5'd0); #1;
    lat = 1;
    while (!out_valid && lat < 40) begin
`ifndef ALU_EXEC_BARREL_SHIFT_EN
      checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL sra_busy: in_ready %b busy %b want 0 1", in_ready, busy); end
`endif
      @(negedge clk); #1; lat++;
    end
    checks++; if (lat !== exp_lat(4'd7, 32'd4)) begin errors++; $display("FAIL sra_latency: got %0d want %0d", lat, exp_lat(4'd7, 32'd4)); end
    checks++; if (out_result !== 32'hF800_0000) begin errors++; $display("FAIL sra_result: got %h want f8000000", out_result); end
    checks++; if (out_tag !== 5'd3 || busy !== 1'b0) begin errors++; $display("FAIL sra_tag_busy: tag %0d busy %b want 3 0", out_tag, busy); end
  endtask

  task automatic test_slt_sltu();
    @(negedge clk); out_ready = 1'b1; set_in(1'b1, 4'd8, 32'hFFFF_FFFF, 32'd1, 5'd4);
    @(negedge clk); set_in(1'b1, 4'd9, 32'hFFFF_FFFF, 32'd1, 5'd5); #1;
    checks++; if (out_result !== 32'd1 || out_tag !== 5'd4) begin errors++; $display("FAIL slt: got %h tag %0d want 1 tag 4", out_result, out_tag); end
    @(negedge clk); set_in(1'b0, 4'd0, 32'd0, 32'd0, 5'd0); #1;
    checks++; if (out_result !== 32'd0 || out_zero !== 1'b1 || out_tag !== 5'd5) begin errors++; $display("FAIL sltu: got %h zero %b tag %0d want 0 1 5", out_result, out_zero, out_tag); end
  endtask

  task automatic test_illegal();
    @(negedge clk); out_ready = 1'b1; set_in(1'b1, 4'b1111, $urandom, $urandom, 5'd7);
    @(negedge clk); set_in(1'b0, 4'd0, 32'd0, 32'd0, 5'd0); #1;
    checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag: valid %b illegal %b want 1 1", out_valid, out_illegal); end
    checks++; if (out_result !== 32'd0 || out_zero !== 1'b1) begin errors++; $display("FAIL illegal_result: got %h zero %b want 0 1", out_result, out_zero); end
    checks++; if (out_tag !== 5'd7) begin errors++; $display("FAIL illegal_tag: got %0d want 7", out_tag); end
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk); out_ready = 1'b0; set_in(1'b1, 4'd0, 32'd3, 32'd4, 5'd8); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready: got %b want 1", in_ready); end
    @(negedge clk); set_in(1'b1, 4'd2, 32'hF0F0_0000, 32'h0F0F_1234, 5'd9); #1;
    repeat (3) begin
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'd7) begin errors++; $display("FAIL bp_hold: ready %b valid %b result %h want 0 1 7", in_ready, out_valid, out_result); end
      @(negedge clk); #1;
    end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", in_ready); end
    @(negedge clk); set_in(1'b1, 4'd5, 32'd1, 32'd3, 5'd10); #1;
    checks++; if (out_result !== 32'hFFFF_1234 || out_tag !== 5'd9) begin errors++; $display("FAIL bp_xor: got %h tag %0d want ffff1234 9", out_result, out_tag); end
    @(negedge clk); set_in(1'b0, 4'd0, 32'd0, 32'd0, 5'd0); out_ready = 1'b0; #1;
    lat = 1;
    while (!out_valid && lat < 40) begin @(negedge clk); #1; lat++; end
    checks++; if (lat !== exp_lat(4'd5, 32'd3)) begin errors++; $display("FAIL bp_sll_latency: got %0d want %0d", lat, exp_lat(4'd5, 32'd3)); end
    repeat (3) begin
      checks++; if (out_valid !== 1'b1 || out_result !== 32'd8 || out_tag !== 5'd10) begin errors++; $display("FAIL bp_sll_hold: valid %b result %h tag %0d want 1 8 10", out_valid, out_result, out_tag); end
      @(negedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_sll_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    @(negedge clk); out_ready = 1'b1; set_in(1'b1, 4'd5, 32'd1, 32'd20, 5'd11);
    @(negedge clk); set_in(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    repeat (4) @(negedge clk);
    flush = 1'b1; set_in(1'b1, 4'd0, 32'd1, 32'd1, 5'd12); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    @(negedge clk); flush = 1'b0; set_in(1'b0, 4'd0, 32'd0, 32'd0, 5'd0); #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_idle: busy %b valid %b want 0 0", busy, out_valid); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_accept: got %b want 0", out_valid); end
    out_ready = 1'b0; set_in(1'b1, 4'd3, 32'h0000_1234, 32'h0000_5600, 5'd13);
    @(negedge clk); set_in(1'b0, 4'd0, 32'd0, 32'd0, 5'd0); #1;
    checks++; if (out_valid !== 1'b1 || out_result !== 32'h0000_5634) begin errors++; $display("FAIL flush_pre: valid %b result %h want 1 5634", out_valid, out_result); end
    flush = 1'b1;
    @(negedge clk); flush = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_slot: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_shift();
    @(negedge clk); out_ready = 1'b0; set_in(1'b1, 4'd6, 32'hFFFF_FFFF, 32'd10, 5'd14);
    @(negedge clk); set_in(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0; #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_state: busy %b valid %b want 0 0", busy, out_valid); end
    checks++; if (out_result !== 32'd0 || out_tag !== 5'd0 || out_zero !== 1'b0 || out_illegal !== 1'b0) begin errors++; $display("FAIL rst_mid_data: result %h tag %0d zero %b illegal %b want 0", out_result, out_tag, out_zero, out_illegal); end
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
  endtask

  typedef struct {
    logic [31:0] res;
    logic        ill;
    logic [4:0]  tag;
  } exp_t;

  task automatic test_random();
    exp_t        q[$];
    exp_t        e;
    logic [32:0] m;
    logic [3:0]  c;
    logic [31:0] b;
    logic        pending;
    int          sent, got, cyc;
    localparam int NOPS = 150;
    pending = 1'b0; sent = 0; got = 0; cyc = 0;
    while (got < NOPS && cyc < 20000) begin
      @(negedge clk); cyc++;
      if (!pending && sent < NOPS && $urandom_range(0, 3) != 0) begin
        c = 4'($urandom_range(0, 11));
        if (c > 4'd9) c = 4'($urandom_range(10, 15));
        b = $urandom;
        if ($urandom_range(0, 3) == 0) b[4:0] = 5'd0;
        set_in(1'b1, c, $urandom, b, 5'($urandom));
        pending = 1'b1;
      end else if (!pending) begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++; $display("FAIL rnd_spurious: result %h with nothing outstanding", out_result);
        end else begin
          e = q.pop_front(); got++;
          checks++; if (out_result !== e.res) begin errors++; $display("FAIL rnd_result: got %h want %h", out_result, e.res); end
          checks++; if (out_illegal !== e.ill || out_zero !== (e.res == 32'd0)) begin errors++; $display("FAIL rnd_flags: illegal %b zero %b want %b %b", out_illegal, out_zero, e.ill, (e.res == 32'd0)); end
          checks++; if (out_tag !== e.tag) begin errors++; $display("FAIL rnd_tag: got %0d want %0d", out_tag, e.tag); end
        end
      end
      if (in_valid && in_ready) begin
        m = ref_alu(in_ctrl, in_a, in_b);
        e.res = m[31:0]; e.ill = m[32]; e.tag = in_tag;
        q.push_back(e);
        pending = 1'b0; sent++;
      end
    end
    in_valid = 1'b0;
    checks++; if (got !== NOPS) begin errors++; $display("FAIL rnd_timeout: got %0d results want %0d", got, NOPS); end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_sra();
    test_slt_sltu();
    test_illegal();
    test_backpressure();
    test_flush();
    test_reset_mid_shift();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 4-bit alu_control code produced by the ALU decoder, plus two operands, and returns a registered result to the writeback/branch logic.
- Valid/ready handshake on both sides.
- Logic/arithmetic/compare ops take 1 cycle; shifts use an iterative 1-bit-per-cycle shifter to save area.

Parameters:
- XLEN, 32, operand/result width.
- TAG_W, 5, width of the passthrough destination-register tag.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort of in-flight work and output slot.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- in_ctrl  in  4  ALU decoder code: 0000 ADD, 0001 SUB, 0010 XOR, 0011 OR, 0100 AND, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU; others illegal.
- in_a  in  XLEN  operand A.
- in_b  in  XLEN  operand B; shift amount is in_b[4:0].
- in_tag  in  TAG_W  destination tag, passed through unchanged.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  consumer accepts the result.
- out_result  out  XLEN  result.
- out_zero  out  1  out_result == 0; used for branch compare.
- out_illegal  out  1  in_ctrl was an undefined code.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, rst_n low): state IDLE; out_valid, out_result, out_zero, out_illegal, out_tag, busy all 0; shift counter 0.
- FSM states:
  - IDLE: in_ready = !flush && (!out_valid || out_ready).
  - SHIFT: in_ready = 0.
- Accept occurs on in_valid && in_ready.
- Non-shift op, or shift with shamt == 0:
  - Result is written to the output register on the accept edge; out_valid = 1 the next cycle (latency 1).
  - Back-to-back throughput is 1 per cycle.
- Shift with shamt n > 0:
  - Accept loads the work register with in_a, counter with n, and the tag; go to SHIFT.
  - Each SHIFT cycle shifts 1 bit (SLL zero-fill, SRL zero-fill, SRA sign-fill) and decrements the counter.
  - When counter == 1 and the output slot is free (!out_valid || out_ready): apply the final shift, commit to the output, return to IDLE. Latency is n+1.
  - When counter == 1 and the slot is not free: stall with work register and counter held.
- Arithmetic: ADD/SUB are modulo 2^XLEN with no overflow flag.
  - SLT: signed compare, result 32'd1 or 32'd0.
  - SLTU: unsigned compare.
- Illegal code: out_result = 0, out_illegal = 1, out_zero = 1; latency 1.
- out_zero is registered alongside out_result.
- Output slot: out_valid clears on out_ready unless a new result commits in the same cycle; in that case it stays 1 with new data.
- flush (synchronous, highest priority after reset): state goes to IDLE and out_valid goes to 0 next cycle. There is no accept in a flush cycle, even with in_valid high. Data registers keep stale values.
- out_ready while out_valid = 0 has no effect.
- Reset asserted mid-shift: the operation is discarded and the FSM goes to IDLE immediately.

Optional Feature:
- Macro: ALU_EXEC_BARREL_SHIFT_EN.
- Defined: shifts use a combinational barrel shifter. All ops take 1 cycle, the SHIFT state is never entered, and busy stays 0.
- Undefined: iterative shifter as described above.
- Handshake semantics are identical in both builds.

Decomposition:
- Package alu_pkg holds:
  - alu_ctrl_e: 4-bit enum of the ten codes above.
  - XLEN_DEFAULT = 32.
  - SHAMT_W = 5.
  - is_shift(ctrl) helper function.
  - The same package is imported by the ALU decoder.
- Sub-module alu_shift_iter: holds the work register, counter and 1-bit step, with load/step/done interface. It is replaced by a combinational shifter under ALU_EXEC_BARREL_SHIFT_EN.

Test Plan:
- ADD: in_a = 32'h7FFF_FFFF, in_b = 1, out_ready = 1 → next cycle out_valid = 1, out_result = 32'h8000_0000, out_zero = 0. Then SUB of 5 − 5 → result 0, out_zero = 1.
- SRA: in_a = 32'h8000_0000, in_b = 4 → in_ready low 4 cycles, busy = 1. out_valid rises 5 cycles after accept with 32'hF800_0000. Barrel build: 1 cycle.
- SLT vs SLTU: in_a = 32'hFFFF_FFFF, in_b = 1 → SLT gives 1, SLTU gives 0.
- Backpressure: hold out_ready = 0 after one result → in_ready = 0 and out_result is stable. A shift with n = 3 stalls at counter == 1 until out_ready = 1, then commits in the same cycle as the handoff.
- Flush mid-SLL (n = 20, at cycle 5) with in_valid high → next cycle state IDLE, out_valid = 0, no accept during the flush cycle. Asserting rst_n low mid-shift drops all outputs to 0 asynchronously.
- Illegal ctrl 4'b1111, tag 5'd7 → out_illegal = 1, out_result = 0, out_tag = 7, latency 1.
